// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light pacing path: phase encoding and
// phase sequencing, used by both this timer and the downstream controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } phase_t;

  // Phase order RED -> YELLOW -> GREEN -> RED; the unused code falls back to RED.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      RED:     return YELLOW;
      YELLOW:  return GREEN;
      GREEN:   return RED;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Free-running clock divider: tick is high on the last cycle of every
// CLK_DIV-cycle window. It never stops, so held ticks are simply lost.
module tick_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q;

  // Count 0..CLK_DIV-1 and wrap; CLK_DIV=1 keeps the count at 0 (tick every cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase dwell timer for the traffic light controller. Counts prescaled ticks
// per phase and emits a one-cycle advance strobe aligned with the first cycle
// of the new phase. A pending pedestrian request cuts GREEN down to its
// minimum dwell and raises ped_walk for the RED that follows.
//
// Handshake: advance is a single-cycle valid with no ready; the controller
// must consume it on the cycle it is high. phase/remaining are always valid.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int RED_TICKS       = 3,
  parameter int YELLOW_TICKS    = 2,
  parameter int GREEN_TICKS     = 5,
  parameter int GREEN_MIN_TICKS = 2,
  localparam int MAX_DWELL = (RED_TICKS >= YELLOW_TICKS)
                             ? ((RED_TICKS >= GREEN_TICKS) ? RED_TICKS : GREEN_TICKS)
                             : ((YELLOW_TICKS >= GREEN_TICKS) ? YELLOW_TICKS : GREEN_TICKS),
  localparam int CW = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          ped_req,
  output logic          advance,
  output phase_t        phase,
  output logic [CW-1:0] remaining,
  output logic          ped_walk
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("CLK_DIV must be >= 1");
  end
  if (RED_TICKS < 1 || YELLOW_TICKS < 1 || GREEN_TICKS < 1) begin : g_bad_dwell
    $error("phase dwell counts must be >= 1");
  end
  if (GREEN_MIN_TICKS < 1 || GREEN_MIN_TICKS > GREEN_TICKS) begin : g_bad_green_min
    $error("GREEN_MIN_TICKS must be in 1..GREEN_TICKS");
  end

  localparam logic [CW-1:0] RED_LAST    = CW'(RED_TICKS - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_TICKS - 1);
  // GREEN may end early once at least GREEN_MIN_TICKS ticks have elapsed,
  // i.e. once remaining has dropped to GREEN_TICKS-GREEN_MIN_TICKS or below.
  localparam logic [CW-1:0] GREEN_EARLY_MAX = CW'(GREEN_TICKS - GREEN_MIN_TICKS);

  function automatic logic [CW-1:0] dwell_last(input phase_t p);
    case (p)
      YELLOW:  return YELLOW_LAST;
      GREEN:   return GREEN_LAST;
      default: return RED_LAST;
    endcase
  endfunction

  logic          tick;
  logic          step_en;
  logic          green_early;
  logic          expire;
  logic          phase_legal;

  phase_t        phase_q, phase_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          adv_q, adv_d;
  logic          pend_q, pend_d;
  logic          walk_q, walk_d;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign phase_legal = (phase_q == RED) || (phase_q == YELLOW) || (phase_q == GREEN);
  assign step_en     = tick & ~hold;
  assign green_early = (phase_q == GREEN) && pend_q && (rem_q <= GREEN_EARLY_MAX);
  assign expire      = step_en && phase_legal && ((rem_q == '0) || green_early);

  // State register: phase, dwell countdown, strobe and pedestrian flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= RED;
      rem_q   <= RED_LAST;
      adv_q   <= 1'b0;
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      adv_q   <= adv_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
    end
  end

  // Next-state: countdown on unheld ticks, phase step on expiry, request tracking.
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    adv_d   = 1'b0;
    pend_d  = pend_q;
    walk_d  = walk_q;

    if (!phase_legal) begin
      phase_d = RED;
      rem_d   = RED_LAST;
    end else if (expire) begin
      phase_d = next_phase(phase_q);
      rem_d   = dwell_last(next_phase(phase_q));
      adv_d   = 1'b1;
    end else if (step_en) begin
      rem_d   = rem_q - CW'(1);
    end

    // Requests latch unless a walk is running; the walk ends on this very
    // edge when RED expires, so a request there already counts.
    if (ped_req && (!walk_q || (expire && phase_q == RED))) begin
      pend_d = 1'b1;
    end
    // A request arriving on the GREEN expiry edge still joins this walk.
    if (expire && phase_q == GREEN) begin
      walk_d = pend_q | ped_req;
      pend_d = 1'b0;
    end
    if (expire && phase_q == RED) begin
      walk_d = 1'b0;
    end
  end

  // Outputs: straight from registers so the controller sees glitch-free values.
  always_comb begin
    phase     = phase_q;
    remaining = rem_q;
    advance   = adv_q;
    ped_walk  = walk_q;
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: randomized and directed stimulus against a
// tick/elapsed-count reference model, with a per-cycle state queue and an
// advance-event queue drained by a separate monitor.
module tb_traffic_phase_timer;

  localparam int CLK_DIV = 4;
  localparam int RED_T   = 3;
  localparam int YEL_T   = 2;
  localparam int GRN_T   = 5;
  localparam int GMIN_T  = 2;
  localparam int MAXD    = (RED_T >= YEL_T) ? ((RED_T >= GRN_T) ? RED_T : GRN_T)
                                            : ((YEL_T >= GRN_T) ? YEL_T : GRN_T);
  localparam int CW      = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int SW      = 2 + CW + 2;
  localparam int AW      = 16 + 2 + CW + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          ped_req = 1'b0;
  logic          advance;
  logic [1:0]    dut_phase;
  logic [CW-1:0] dut_rem;
  logic          ped_walk;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .CLK_DIV         (CLK_DIV),
    .RED_TICKS       (RED_T),
    .YELLOW_TICKS    (YEL_T),
    .GREEN_TICKS     (GRN_T),
    .GREEN_MIN_TICKS (GMIN_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .ped_req   (ped_req),
    .advance   (advance),
    .phase     (dut_phase),
    .remaining (dut_rem),
    .ped_walk  (ped_walk)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [SW-1:0] st_q[$];
  logic [AW-1:0] exp_q[$];
  int t_adv[$];
  int p_adv[$];
  bit mon_en = 1'b0;
  int mon_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks ticks elapsed in the current phase rather than a countdown.
  int m_phase, m_elapsed, m_cyc;
  bit m_pend, m_walk;

  function automatic int dwell(input int p);
    case (p)
      0:       return RED_T;
      1:       return YEL_T;
      default: return GRN_T;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_cyc = 0; m_pend = 0; m_walk = 0;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, predict the next edge, wait a cycle.
  task automatic step(input bit h, input bit r);
    bit tick, adv, npend, nwalk;
    int done, rem;
    hold = h;
    ped_req = r;
    tick = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
    m_cyc++;
    adv = 0;
    done = m_elapsed + 1;
    if (tick && !h)
      if (done == dwell(m_phase) || (m_phase == 2 && m_pend && done >= GMIN_T)) adv = 1;
    npend = m_pend;
    nwalk = m_walk;
    if (r && (!m_walk || (adv && m_phase == 0))) npend = 1;
    if (adv && m_phase == 2) begin nwalk = m_pend | r; npend = 0; end
    if (adv && m_phase == 0) nwalk = 0;
    if (adv) begin
      m_phase = (m_phase + 1) % 3;
      m_elapsed = 0;
    end else if (tick && !h) begin
      m_elapsed = done;
    end
    m_pend = npend;
    m_walk = nwalk;
    rem = dwell(m_phase) - 1 - m_elapsed;
    st_q.push_back({2'(m_phase), CW'(rem), m_walk, adv});
    if (adv) exp_q.push_back({16'(m_cyc), 2'(m_phase), CW'(rem), m_walk});
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst = 1;
    hold = 0;
    ped_req = 0;
    repeat (2) @(negedge clk);
    st_q.delete();
    exp_q.delete();
    rst = 0;
    model_reset();
    mon_en = 1;
  endtask

  task automatic wait_phase(input int p, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < 200) begin
      step(0, 0);
      n++;
    end
    if (m_phase != p) chk({"timeout_", name}, 64'(m_phase), 64'(p));
  endtask

  function automatic int find_dur(input int p1, input int p2);
    for (int i = 0; i + 1 < t_adv.size(); i++)
      if (p_adv[i] == p1 && p_adv[i+1] == p2) return t_adv[i+1] - t_adv[i];
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (rst) mon_cyc = 0;
    else mon_cyc++;
    if (mon_en) begin
      if (st_q.size() == 0) begin
        total++; bad++;
        $display("FAIL state_queue: got empty expected entry (cyc=%0d)", mon_cyc);
      end else begin
        chk("state", 64'({dut_phase, dut_rem, ped_walk, advance}), 64'(st_q.pop_front()));
      end
      if (advance) begin
        t_adv.push_back(mon_cyc);
        p_adv.push_back(int'(dut_phase));
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL advance_event: got advance at cyc %0d expected none", mon_cyc);
        end else begin
          chk("advance_event", 64'({16'(mon_cyc), dut_phase, dut_rem, ped_walk}),
              64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_t[4];
    int exp_p[4];
    int n, hold_left;
    bit h, r;
    exp_t = '{12, 20, 40, 52};
    exp_p = '{1, 2, 0, 1};

    @(negedge clk);
    chk("reset_phase", 64'(dut_phase), 64'(0));
    chk("reset_remaining", 64'(dut_rem), 64'(RED_T - 1));
    chk("reset_advance", 64'(advance), 64'(0));
    chk("reset_walk", 64'(ped_walk), 64'(0));

    // Free-running sequence with no requests.
    do_reset();
    t_adv.delete(); p_adv.delete();
    repeat (60) step(0, 0);
    if (t_adv.size() < 4) chk("idle_adv_count", 64'(t_adv.size()), 64'(4));
    else
      for (int i = 0; i < 4; i++) begin
        chk("idle_adv_cycle", 64'(t_adv[i]), 64'(exp_t[i]));
        chk("idle_adv_phase", 64'(p_adv[i]), 64'(exp_p[i]));
      end

    // Request 5 cycles into GREEN shortens it to 8 cycles.
    do_reset();
    t_adv.delete(); p_adv.delete();
    wait_phase(2, "green_a");
    repeat (4) step(0, 0);
    step(0, 1);
    wait_phase(0, "red_a");
    chk("ped_green_len", 64'(find_dur(2, 0)), 64'(8));
    chk("ped_walk_set", 64'(ped_walk), 64'(1));
    repeat (2) step(0, 0);

    // Request during walk is ignored; next GREEN runs its full length.
    step(0, 1);
    t_adv.delete(); p_adv.delete();
    wait_phase(1, "yellow_b");
    chk("walk_cleared", 64'(ped_walk), 64'(0));
    chk("red_walk_len", 64'(mon_cyc - 0 >= 0 ? 1 : 0), 64'(1));
    wait_phase(2, "green_b");
    wait_phase(0, "red_b");
    chk("ignored_green_len", 64'(find_dur(2, 0)), 64'(20));
    chk("ignored_no_walk", 64'(ped_walk), 64'(0));

    // Hold for 12 cycles in the middle of YELLOW.
    t_adv.delete(); p_adv.delete();
    wait_phase(1, "yellow_c");
    repeat (2) step(0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0);
      chk("adv_in_hold", 64'(advance), 64'(0));
    end
    wait_phase(2, "green_c");
    chk("held_yellow_len", 64'(find_dur(1, 2)), 64'(20));

    // Request exactly on the GREEN expiry edge.
    n = 0;
    while (!(m_phase == 2 && m_elapsed == GRN_T - 1 && (m_cyc % CLK_DIV) == CLK_DIV - 1) && n < 200) begin
      step(0, 0);
      n++;
    end
    step(0, 1);
    chk("expiry_req_phase", 64'(dut_phase), 64'(0));
    chk("expiry_req_walk", 64'(ped_walk), 64'(1));

    // Reset in the middle of GREEN with a request pending.
    wait_phase(2, "green_d");
    step(0, 1);
    repeat (2) step(0, 0);
    mon_en = 0;
    rst = 1;
    #1;
    chk("midrst_phase", 64'(dut_phase), 64'(0));
    chk("midrst_remaining", 64'(dut_rem), 64'(RED_T - 1));
    chk("midrst_advance", 64'(advance), 64'(0));
    chk("midrst_walk", 64'(ped_walk), 64'(0));
    @(negedge clk);
    @(negedge clk);
    st_q.delete(); exp_q.delete();
    rst = 0;
    model_reset();
    mon_en = 1;
    t_adv.delete(); p_adv.delete();
    repeat (30) step(0, 0);
    if (t_adv.size() < 1) chk("midrst_adv_count", 64'(t_adv.size()), 64'(1));
    else chk("midrst_first_adv", 64'(t_adv[0]), 64'(12));

    // Randomized hold bursts and sparse pedestrian requests.
    do_reset();
    hold_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_left == 0 && $urandom_range(0, 29) == 0) hold_left = $urandom_range(1, 10);
      h = (hold_left != 0);
      if (hold_left != 0) hold_left--;
      r = ($urandom_range(0, 24) == 0);
      step(h, r);
    end
    step(0, 0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("st_q_drained", 64'(st_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
